// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// uart_tx_scheduler: round-robin grant of NREQ byte producers onto one 8N1 TX
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_scheduler #(
  parameter int NREQ    = 4,
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OW      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DBIT-1:0] din,
  output logic [NREQ-1:0]      gnt,
  output logic [OW-1:0]        owner,
  output logic                 busy,
  output logic                 tx,
  output logic                 tx_done_tick
);

  localparam int TW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int BW = $clog2(DBIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   nbit_q, nbit_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [OW-1:0]   last_q, last_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  logic [OW-1:0]   pick;
  logic            found;

  // Search starts one past the last winner so it drops to lowest priority.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    nbit_d  = nbit_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    owner_d = owner_q;
    gnt_d   = '0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          shreg_d = din[int'(pick)*DBIT +: DBIT];
          gnt_d   = NREQ'(1) << pick;
          owner_d = pick;
          last_d  = pick;
          tick_d  = '0;
          nbit_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == TW'(15)) begin
            tick_d  = '0;
            state_d = DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == TW'(15)) begin
            tick_d  = '0;
            shreg_d = shreg_q >> 1;
            if (nbit_q == BW'(DBIT - 1)) begin
              state_d = STOP;
            end else begin
              nbit_d = nbit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == TW'(SB_TICK - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so tx is a clean flop output.
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      nbit_q  <= '0;
      shreg_q <= '0;
      last_q  <= OW'(NREQ - 1);
      owner_q <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      nbit_q  <= nbit_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign gnt          = gnt_q;
  assign owner        = owner_q;
  assign busy         = busy_q;
  assign tx           = tx_q;
  assign tx_done_tick = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
// tb_uart_tx_scheduler: vector table + scoreboard bench for uart_tx_scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

  localparam int NREQ = 4;
  localparam int DBIT = 8;
  localparam int M    = 651;

  logic                 clk    = 1'b0;
  logic                 reset  = 1'b1;
  logic                 s_tick = 1'b1;
  logic [NREQ-1:0]      req    = '0;
  logic [NREQ*DBIT-1:0] din    = '0;
  logic [NREQ-1:0]      gnt;
  logic [1:0]           owner;
  logic                 busy;
  logic                 tx;
  logic                 tx_done_tick;

  uart_tx_scheduler #(.NREQ(NREQ), .DBIT(DBIT), .SB_TICK(16), .OW(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .req          (req),
    .din          (din),
    .gnt          (gnt),
    .owner        (owner),
    .busy         (busy),
    .tx           (tx),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  // Tick source: tied high, or a mod-M counter like the shared baud generator.
  int tick_mode = 0;
  int tick_cnt  = 0;
  always @(negedge clk) begin
    if (tick_mode != 0) begin
      tick_cnt = (tick_cnt == M - 1) ? 0 : tick_cnt + 1;
      s_tick   = (tick_cnt == M - 1);
    end else begin
      s_tick = 1'b1;
    end
  end

  typedef struct {
    logic [1:0] owner;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [7:0] base;
    logic [1:0] exp_owner;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic set_din(input logic [7:0] base);
    for (int i = 0; i < NREQ; i++) din[i*DBIT +: DBIT] = base + 8'(i);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits for a grant, pops the expected record and follows the whole frame.
  task automatic check_frame(input logic [3:0] after_req, input logic [3:0] late_req,
                             input bit scramble, output int waited);
    exp_t       e;
    logic [9:0] bits;
    bit         bad_busy;
    bit         bad_gnt;
    int         done_at;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (gnt == '0 && waited < 64);
    if (gnt == '0) begin
      n_checks++;
      $display("FAIL grant_timeout: got no gnt, expected one within 64 cycles");
      return;
    end
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard: got gnt %0h, expected no grant", gnt);
      return;
    end
    e   = sb_q.pop_front();
    req = after_req;
    if (scramble) din = $urandom;
    chk("gnt", 32'(gnt), 32'(4'b0001 << e.owner));
    chk("owner", 32'(owner), 32'(e.owner));
    bits     = {1'b1, e.data, 1'b0};
    done_at  = -1;
    bad_busy = 1'b0;
    bad_gnt  = 1'b0;
    for (int c = 1; c <= 160; c++) begin
      @(negedge clk);
      if (c % 16 == 8) chk($sformatf("tx_bit%0d", c / 16), 32'(tx), 32'(bits[c/16]));
      if (c < 160 && busy !== 1'b1) bad_busy = 1'b1;
      if (gnt !== '0) bad_gnt = 1'b1;
      if (tx_done_tick === 1'b1 && done_at < 0) done_at = c;
      if (c == 150 && late_req != '0) req = late_req;
    end
    chk("done_cycle", 32'(done_at), 32'd160);
    chk("busy_held", 32'(bad_busy), 32'd0);
    chk("no_extra_gnt", 32'(bad_gnt), 32'd0);
    chk("idle_gap_tx", 32'(tx), 32'd1);
    chk("busy_drop", 32'(busy), 32'd0);
  endtask

  initial begin
    int  w;
    int  n;
    int  m;
    bit  bad;

    vecs[0] = '{4'b0100, 8'hA3, 2'd2};  // slice 2 = 0xA5
    vecs[1] = '{4'b0010, 8'h3C, 2'd1};
    vecs[2] = '{4'b0011, 8'h5A, 2'd0};  // after 1: search 2,3 then wraps to 0
    vecs[3] = '{4'b1001, 8'hC3, 2'd3};
    vecs[4] = '{4'b1001, 8'h81, 2'd0};
    vecs[5] = '{4'b0110, 8'h7E, 2'd1};
    vecs[6] = '{4'b1000, 8'hF0, 2'd3};
    vecs[7] = '{4'b0001, 8'h00, 2'd0};

    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done_tick), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      req = vecs[i].req;
      set_din(vecs[i].base);
      sb_q.push_back('{vecs[i].exp_owner, vecs[i].base + 8'(vecs[i].exp_owner)});
      check_frame(4'b0000, 4'b0000, 1'b1, w);
      chk("latency", 32'(w), 32'd1);
    end

    do_reset();
    req = 4'b1111;
    set_din(8'h10);
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back('{2'(i % 4), 8'h10 + 8'(i % 4)});
      check_frame(4'b1111, 4'b0000, 1'b0, w);
      chk("contention_latency", 32'(w), 32'd1);
    end
    req = 4'b0000;

    do_reset();
    req = 4'b0010;
    set_din(8'h40);
    sb_q.push_back('{2'd1, 8'h41});
    check_frame(4'b0000, 4'b0001, 1'b0, w);
    sb_q.push_back('{2'd0, 8'h40});
    check_frame(4'b0000, 4'b0000, 1'b0, w);
    chk("holdoff_latency", 32'(w), 32'd1);

    // Abandon a frame in data bit 3 with an asynchronous reset.
    do_reset();
    req = 4'b0001;
    set_din(8'h96);
    w = 0;
    do begin @(negedge clk); w++; end while (gnt == '0 && w < 64);
    chk("mid_owner", 32'(owner), 32'd0);
    req = 4'b0000;
    repeat (72) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    bad = 1'b0;
    repeat (2) begin @(negedge clk); if (tx_done_tick !== 1'b0) bad = 1'b1; end
    reset = 1'b0;
    repeat (20) begin @(negedge clk); if (tx_done_tick !== 1'b0) bad = 1'b1; end
    chk("mid_no_done", 32'(bad), 32'd0);
    req = 4'b1000;
    sb_q.push_back('{2'd3, 8'h96 + 8'd3});
    check_frame(4'b0000, 4'b0000, 1'b0, w);

    // Real baud: start bit and first data bit timed against the mod-651 tick.
    do_reset();
    tick_mode = 1;
    req = 4'b0100;
    set_din(8'hA3);
    w = 0;
    do begin @(negedge clk); w++; end while (gnt == '0 && w < 64);
    chk("rb_owner", 32'(owner), 32'd2);
    req = 4'b0000;
    bad = 1'b0;
    n = 0;
    while (tx == 1'b0 && n < 20000) begin
      @(negedge clk); n++;
      if (busy !== 1'b1) bad = 1'b1;
    end
    chk("rb_start_len_ok", 32'(n > 15 * M && n <= 16 * M), 32'd1);
    m = 0;
    while (tx == 1'b1 && m < 20000) begin
      @(negedge clk); m++;
      if (busy !== 1'b1) bad = 1'b1;
    end
    chk("rb_bit0_len", 32'(m), 32'(16 * M));
    chk("rb_busy_held", 32'(bad), 32'd0);
    tick_mode = 0;
    do_reset();
    chk("rb_scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
